// File: rtl/bus_pkg.sv
// Shared widths, request bundle and counter-width helper for the bus bridge.
package bus_pkg;

    localparam int unsigned BUS_ADDR_W    = 32;
    localparam int unsigned BUS_DATA_W    = 32;
    localparam int unsigned BUS_ID_W      = 4;
    localparam int unsigned BUS_MAX_OUTST = 8;
    localparam int unsigned BUS_TIMEOUT   = 1024;

    typedef struct packed {
        logic [BUS_ADDR_W-1:0] addr;
        logic                  write;
        logic [BUS_ID_W-1:0]   id;
    } bus_req_t;

    function automatic int unsigned cnt_width(input int unsigned max_outst);
        return $clog2(max_outst + 1);
    endfunction

endpackage

// File: rtl/bus_skid_slice.sv
// Two-entry valid/ready register slice: main output register plus skid entry.
module bus_skid_slice #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             main_v_q, main_v_d;
    logic             skid_v_q, skid_v_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;

    // Ready comes straight from a register so the master path stays short.
    assign in_ready_o  = !skid_v_q;
    assign out_valid_o = main_v_q;
    assign out_data_o  = main_q;

    always_comb begin
        main_v_d = main_v_q;
        main_d   = main_q;
        skid_v_d = skid_v_q;
        skid_d   = skid_q;
        if (out_ready_i || !main_v_q) begin
            if (skid_v_q) begin
                main_v_d = 1'b1;
                main_d   = skid_q;
                skid_v_d = 1'b0;
            end else begin
                main_v_d = in_valid_i;
                if (in_valid_i) begin
                    main_d = in_data_i;
                end
            end
        end else if (in_valid_i && !skid_v_q) begin
            skid_v_d = 1'b1;
            skid_d   = in_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
        end
    end

endmodule

// File: rtl/bus_bridge_tracker.sv
// Registered master/slave bridge with per-ID outstanding tracking, write-data
// ordering, unexpected-response dropping and a response watchdog.
module bus_bridge_tracker
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = BUS_ADDR_W,
    parameter int unsigned DATA_WIDTH     = BUS_DATA_W,
    parameter int unsigned ID_WIDTH       = BUS_ID_W,
    parameter int unsigned MAX_OUTST      = BUS_MAX_OUTST,
    parameter int unsigned TIMEOUT_CYCLES = BUS_TIMEOUT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              m_req_valid_i,
    input  logic [ADDR_WIDTH-1:0]             m_req_addr_i,
    input  logic                              m_req_write_i,
    input  logic [ID_WIDTH-1:0]               m_req_id_i,
    output logic                              m_req_ready_o,
    input  logic                              m_data_valid_i,
    input  logic [DATA_WIDTH-1:0]             m_data_i,
    input  logic [DATA_WIDTH/8-1:0]           m_data_strb_i,
    output logic                              m_data_ready_o,
    output logic                              m_resp_valid_o,
    output logic [DATA_WIDTH-1:0]             m_resp_data_o,
    output logic [ID_WIDTH-1:0]               m_resp_id_o,
    output logic                              m_resp_error_o,
    input  logic                              m_resp_ready_i,
    output logic                              s_req_valid_o,
    output logic [ADDR_WIDTH-1:0]             s_req_addr_o,
    output logic                              s_req_write_o,
    output logic [ID_WIDTH-1:0]               s_req_id_o,
    input  logic                              s_req_ready_i,
    output logic                              s_data_valid_o,
    output logic [DATA_WIDTH-1:0]             s_data_o,
    output logic [DATA_WIDTH/8-1:0]           s_data_strb_o,
    input  logic                              s_data_ready_i,
    input  logic                              s_resp_valid_i,
    input  logic [DATA_WIDTH-1:0]             s_resp_data_i,
    input  logic [ID_WIDTH-1:0]               s_resp_id_i,
    input  logic                              s_resp_error_i,
    output logic                              s_resp_ready_o,
    output logic [cnt_width(MAX_OUTST)-1:0]   outst_cnt_o,
    output logic                              err_unexp_id_o,
    output logic                              timeout_o,
    input  logic                              clr_status_i
);

    localparam int unsigned CW  = cnt_width(MAX_OUTST);
    localparam int          NID = 1 << ID_WIDTH;
    localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  MAX_C  = CW'(MAX_OUTST);
    localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT_CYCLES - 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  write;
        logic [ID_WIDTH-1:0]   id;
    } req_t;

    req_t           m_req, s_req;
    logic           slice_in_ready, slice_in_valid, room;
    logic           req_hs, resp_hs, resp_exp, resp_drop;
    logic           sreq_wr_hs, sdata_hs, cred_ok;
    logic [NID-1:0] id_inc, id_dec;

    logic [CW-1:0]  outst_q, outst_d;
    logic [CW-1:0]  credit_q, credit_d;
    logic [CW-1:0]  id_cnt_q [NID];
    logic [CW-1:0]  id_cnt_d [NID];
    logic [WDW-1:0] wd_q, wd_d;
    logic           timeout_q, timeout_d;
    logic           err_q, err_d;

    assign m_req = '{addr: m_req_addr_i, write: m_req_write_i, id: m_req_id_i};

    assign room           = outst_q < MAX_C;
    assign slice_in_valid = m_req_valid_i && room;
    assign m_req_ready_o  = slice_in_ready && room;
    assign req_hs         = m_req_valid_i && m_req_ready_o;

    bus_skid_slice #(
        .WIDTH($bits(req_t))
    ) u_req_slice (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (slice_in_valid),
        .in_ready_o  (slice_in_ready),
        .in_data_i   (m_req),
        .out_valid_o (s_req_valid_o),
        .out_ready_i (s_req_ready_i),
        .out_data_o  (s_req)
    );

    assign s_req_addr_o  = s_req.addr;
    assign s_req_write_o = s_req.write;
    assign s_req_id_o    = s_req.id;

    // Data may only follow a write request that already reached the slave.
    assign cred_ok        = credit_q != '0;
    assign s_data_valid_o = m_data_valid_i && cred_ok;
    assign m_data_ready_o = s_data_ready_i && cred_ok;
    assign s_data_o       = m_data_i;
    assign s_data_strb_o  = m_data_strb_i;
    assign sdata_hs       = s_data_valid_o && s_data_ready_i;
    assign sreq_wr_hs     = s_req_valid_o && s_req_ready_i && s_req_write_o;

    assign resp_exp       = id_cnt_q[s_resp_id_i] != '0;
    assign resp_drop      = s_resp_valid_i && !resp_exp;
    assign m_resp_valid_o = s_resp_valid_i && resp_exp;
    assign s_resp_ready_o = resp_exp ? m_resp_ready_i : s_resp_valid_i;
    assign m_resp_data_o  = s_resp_data_i;
    assign m_resp_id_o    = s_resp_id_i;
    assign m_resp_error_o = s_resp_error_i;
    assign resp_hs        = m_resp_valid_o && m_resp_ready_i;

    assign id_inc = req_hs  ? (NID'(1) << m_req_id_i)  : '0;
    assign id_dec = resp_hs ? (NID'(1) << s_resp_id_i) : '0;

    assign outst_cnt_o    = outst_q;
    assign err_unexp_id_o = err_q;
    assign timeout_o      = timeout_q;

    always_comb begin
        outst_d = outst_q;
        if (req_hs && !resp_hs) begin
            outst_d = outst_q + CW'(1);
        end else if (!req_hs && resp_hs) begin
            outst_d = outst_q - CW'(1);
        end

        for (int i = 0; i < NID; i++) begin
            id_cnt_d[i] = id_cnt_q[i];
            unique case ({id_inc[i], id_dec[i]})
                2'b10:   id_cnt_d[i] = id_cnt_q[i] + CW'(1);
                2'b01:   id_cnt_d[i] = id_cnt_q[i] - CW'(1);
                default: id_cnt_d[i] = id_cnt_q[i];
            endcase
        end

        credit_d = credit_q;
        if (sreq_wr_hs && !sdata_hs && credit_q != MAX_C) begin
            credit_d = credit_q + CW'(1);
        end else if (!sreq_wr_hs && sdata_hs) begin
            credit_d = credit_q - CW'(1);
        end

        wd_d = wd_q;
        if (outst_q == '0 || resp_hs || clr_status_i) begin
            wd_d = '0;
        end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + WDW'(1);
        end

        // Flag sets on the edge where the count reaches its terminal value.
        timeout_d = timeout_q;
        if (clr_status_i) begin
            timeout_d = 1'b0;
        end else if (wd_d == WD_MAX) begin
            timeout_d = 1'b1;
        end

        err_d = resp_drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outst_q   <= '0;
            credit_q  <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < NID; i++) begin
                id_cnt_q[i] <= '0;
            end
        end else begin
            outst_q   <= outst_d;
            credit_q  <= credit_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            id_cnt_q  <= id_cnt_d;
        end
    end

endmodule
